// File: rtl/sdram_host_arbiter.sv
// Two-port round-robin arbiter that shares one SDRAM controller host port
// between host A and host B. Each grant issues exactly one controller
// transaction. Completion is reported to the owning port with a one-cycle ack.
module sdram_host_arbiter #(
   parameter int HADDR_WIDTH = 24
) (
   input  logic                   clk,
   input  logic                   rst,

   // host port A
   input  logic                   a_req,
   input  logic                   a_we,
   input  logic [HADDR_WIDTH-1:0] a_addr,
   input  logic [15:0]            a_wdata,
   output logic                   a_ack,
   output logic [15:0]            a_rdata,

   // host port B
   input  logic                   b_req,
   input  logic                   b_we,
   input  logic [HADDR_WIDTH-1:0] b_addr,
   input  logic [15:0]            b_wdata,
   output logic                   b_ack,
   output logic [15:0]            b_rdata,

   // ownership
   output logic [1:0]             grant,

   // SDRAM controller host port
   output logic                   wr_enable,
   output logic                   rd_enable,
   output logic [HADDR_WIDTH-1:0] wr_addr,
   output logic [HADDR_WIDTH-1:0] rd_addr,
   output logic [15:0]            wr_data,
   input  logic                   busy,
   input  logic                   rd_ready,
   input  logic [15:0]            rd_data
);

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT
   } arb_state_e;

   arb_state_e             state_q,      state_d;
   logic                   owner_b_q,    owner_b_d;    // 0 = A owns, 1 = B owns
   logic                   last_b_q,     last_b_d;     // 1 = B was granted last
   logic                   we_q,         we_d;
   logic [1:0]             grant_q,      grant_d;
   logic                   wr_enable_q,  wr_enable_d;
   logic                   rd_enable_q,  rd_enable_d;
   logic [HADDR_WIDTH-1:0] addr_q,       addr_d;
   logic [15:0]            wr_data_q,    wr_data_d;
   logic                   a_ack_q,      a_ack_d;
   logic                   b_ack_q,      b_ack_d;
   logic [15:0]            a_rdata_q,    a_rdata_d;
   logic [15:0]            b_rdata_q,    b_rdata_d;
   logic                   pick_b;

   // Next-state and next-output computation for the arbiter FSM.
   always_comb begin
      state_d     = state_q;
      owner_b_d   = owner_b_q;
      last_b_d    = last_b_q;
      we_d        = we_q;
      grant_d     = grant_q;
      wr_enable_d = wr_enable_q;
      rd_enable_d = rd_enable_q;
      addr_d      = addr_q;
      wr_data_d   = wr_data_q;
      a_ack_d     = 1'b0;
      b_ack_d     = 1'b0;
      a_rdata_d   = a_rdata_q;
      b_rdata_d   = b_rdata_q;
      pick_b      = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            // The acked port still shows req during its ack cycle, so no
            // selection is made while an ack is out; this prevents a
            // duplicate transaction and gives the two-cycle ack-to-enable gap.
            if (!(a_ack_q || b_ack_q) && (a_req || b_req)) begin
               pick_b      = b_req && (!a_req || !last_b_q);
               owner_b_d   = pick_b;
               last_b_d    = pick_b;
               we_d        = pick_b ? b_we    : a_we;
               addr_d      = pick_b ? b_addr  : a_addr;
               wr_data_d   = pick_b ? b_wdata : a_wdata;
               grant_d     = pick_b ? 2'b10   : 2'b01;
               wr_enable_d = pick_b ? b_we    : a_we;
               rd_enable_d = pick_b ? !b_we   : !a_we;
               state_d     = ARB_ISSUE;
            end
         end

         ARB_ISSUE: begin
            // Hold the command until the controller shows it has taken it.
            if (busy) begin
               wr_enable_d = 1'b0;
               rd_enable_d = 1'b0;
               state_d     = ARB_WAIT;
            end
         end

         ARB_WAIT: begin
            if (rd_ready && !we_q) begin
               if (owner_b_q) b_rdata_d = rd_data;
               else           a_rdata_d = rd_data;
            end
            if (!busy) begin
               a_ack_d = !owner_b_q;
               b_ack_d = owner_b_q;
               grant_d = 2'b00;
               state_d = ARB_IDLE;
            end
         end

         default: begin
            state_d     = ARB_IDLE;
            grant_d     = 2'b00;
            wr_enable_d = 1'b0;
            rd_enable_d = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         owner_b_q   <= 1'b0;
         last_b_q    <= 1'b1;
         we_q        <= 1'b0;
         grant_q     <= 2'b00;
         wr_enable_q <= 1'b0;
         rd_enable_q <= 1'b0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         a_ack_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         owner_b_q   <= owner_b_d;
         last_b_q    <= last_b_d;
         we_q        <= we_d;
         grant_q     <= grant_d;
         wr_enable_q <= wr_enable_d;
         rd_enable_q <= rd_enable_d;
         addr_q      <= addr_d;
         wr_data_q   <= wr_data_d;
         a_ack_q     <= a_ack_d;
         b_ack_q     <= b_ack_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
      end
   end

   assign grant     = grant_q;
   assign wr_enable = wr_enable_q;
   assign rd_enable = rd_enable_q;
   assign wr_addr   = addr_q;
   assign rd_addr   = addr_q;
   assign wr_data   = wr_data_q;
   assign a_ack     = a_ack_q;
   assign b_ack     = b_ack_q;
   assign a_rdata   = a_rdata_q;
   assign b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Directed bench for sdram_host_arbiter: a cycle table for a single write and
// a single read, then hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_sdram_host_arbiter;
   localparam int AW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [15:0]   a_wdata, b_wdata;
   logic          a_ack, b_ack;
   logic [15:0]   a_rdata, b_rdata;
   logic [1:0]    grant;
   logic          wr_enable, rd_enable;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [15:0]   wr_data;
   logic          busy, rd_ready;
   logic [15:0]   rd_data;

   sdram_host_arbiter #(.HADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .grant(grant),
      .wr_enable(wr_enable), .rd_enable(rd_enable),
      .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data),
      .busy(busy), .rd_ready(rd_ready), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Inputs change at the falling edge; outputs are sampled at the next falling edge.
   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
      busy = 0; rd_ready = 0; rd_data = '0;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   typedef struct {
      logic          a_req, b_req, busy, rdy;
      logic [15:0]   rdd;
      logic [1:0]    grant;
      logic          wen, ren, aack, back;
      logic [15:0]   ardata, brdata;
      logic          chk_addr;
      logic [AW-1:0] addr;
      logic          chk_wd;
      logic [15:0]   wd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic ar, logic br, logic bs, logic ry, logic [15:0] rd,
                               logic [1:0] g, logic we, logic re, logic aa, logic ba,
                               logic [15:0] ard, logic [15:0] brd,
                               logic ca, logic [AW-1:0] ad, logic cw, logic [15:0] w);
      vec_t v;
      v.a_req = ar; v.b_req = br; v.busy = bs; v.rdy = ry; v.rdd = rd;
      v.grant = g; v.wen = we; v.ren = re; v.aack = aa; v.back = ba;
      v.ardata = ard; v.brdata = brd;
      v.chk_addr = ca; v.addr = ad; v.chk_wd = cw; v.wd = w;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] act_wa, act_ra, exp_a;
      logic [15:0]   act_wd, exp_wd;
      logic [1:0]    exp_g;
      logic [AW-1:0] exp_addr;
      int            waited, acks, others, ens, ack_seen;
      logic          hold_ok;

      // ---------------- reset state ----------------
      clear_inputs();
      rst = 1;
      #2;
      check("reset_state", {grant, wr_enable, rd_enable, a_ack, b_ack, wr_addr, rd_addr,
                            wr_data, a_rdata, b_rdata}, '0);
      tick();
      tick();
      rst = 0;

      // ---------------- table: single A write, then single B read ----------------
      //           areq breq busy rdy rdd       grant  wen ren aack back ardata  brdata     ca addr         cw wd
      vecs.push_back(mk(1, 0, 0, 0, 16'h0,    2'b01, 1, 0, 0, 0, 16'h0, 16'h0,    1, 24'h012345, 1, 16'hBEEF));
      vecs.push_back(mk(1, 0, 0, 0, 16'h0,    2'b01, 1, 0, 0, 0, 16'h0, 16'h0,    1, 24'h012345, 1, 16'hBEEF));
      vecs.push_back(mk(1, 0, 0, 0, 16'h0,    2'b01, 1, 0, 0, 0, 16'h0, 16'h0,    1, 24'h012345, 1, 16'hBEEF));
      vecs.push_back(mk(1, 0, 1, 0, 16'h0,    2'b01, 0, 0, 0, 0, 16'h0, 16'h0,    1, 24'h012345, 0, 16'h0));
      vecs.push_back(mk(1, 0, 1, 0, 16'h0,    2'b01, 0, 0, 0, 0, 16'h0, 16'h0,    1, 24'h012345, 0, 16'h0));
      vecs.push_back(mk(1, 0, 1, 0, 16'h0,    2'b01, 0, 0, 0, 0, 16'h0, 16'h0,    1, 24'h012345, 0, 16'h0));
      vecs.push_back(mk(1, 0, 1, 0, 16'h0,    2'b01, 0, 0, 0, 0, 16'h0, 16'h0,    1, 24'h012345, 0, 16'h0));
      vecs.push_back(mk(1, 0, 1, 0, 16'h0,    2'b01, 0, 0, 0, 0, 16'h0, 16'h0,    1, 24'h012345, 0, 16'h0));
      vecs.push_back(mk(1, 0, 0, 0, 16'h0,    2'b00, 0, 0, 1, 0, 16'h0, 16'h0,    0, 24'h0,      0, 16'h0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0,    2'b00, 0, 0, 0, 0, 16'h0, 16'h0,    0, 24'h0,      0, 16'h0));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0,    2'b10, 0, 1, 0, 0, 16'h0, 16'h0,    1, 24'h000010, 0, 16'h0));
      vecs.push_back(mk(0, 1, 1, 0, 16'h0,    2'b10, 0, 0, 0, 0, 16'h0, 16'h0,    1, 24'h000010, 0, 16'h0));
      vecs.push_back(mk(0, 1, 1, 1, 16'h1234, 2'b10, 0, 0, 0, 0, 16'h0, 16'h1234, 1, 24'h000010, 0, 16'h0));
      vecs.push_back(mk(0, 1, 0, 0, 16'h0,    2'b00, 0, 0, 0, 1, 16'h0, 16'h1234, 0, 24'h0,      0, 16'h0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0,    2'b00, 0, 0, 0, 0, 16'h0, 16'h1234, 0, 24'h0,      0, 16'h0));

      a_we = 1; a_addr = 24'h012345; a_wdata = 16'hBEEF;
      b_we = 0; b_addr = 24'h000010; b_wdata = 16'h5555;
      foreach (vecs[i]) begin
         a_req = vecs[i].a_req; b_req = vecs[i].b_req; busy = vecs[i].busy;
         rd_ready = vecs[i].rdy; rd_data = vecs[i].rdd;
         tick();
         act_wa = vecs[i].chk_addr ? wr_addr : '0;
         act_ra = vecs[i].chk_addr ? rd_addr : '0;
         exp_a  = vecs[i].chk_addr ? vecs[i].addr : '0;
         act_wd = vecs[i].chk_wd ? wr_data : '0;
         exp_wd = vecs[i].chk_wd ? vecs[i].wd : '0;
         check($sformatf("vec%0d", i),
               {grant, wr_enable, rd_enable, a_ack, b_ack, a_rdata, b_rdata, act_wa, act_ra, act_wd},
               {vecs[i].grant, vecs[i].wen, vecs[i].ren, vecs[i].aack, vecs[i].back,
                vecs[i].ardata, vecs[i].brdata, exp_a, exp_a, exp_wd});
      end

      // ---------------- reset asserted in ARB_WAIT ----------------
      b_we = 1; b_addr = 24'h000777; b_wdata = 16'h7777; b_req = 1;
      tick();
      check("rstw_issue", {grant, wr_enable, wr_addr}, {2'b10, 1'b1, 24'h000777});
      busy = 1;
      tick();
      check("rstw_wait", {grant, wr_enable, rd_enable}, {2'b10, 2'b00});
      #2 rst = 1; busy = 0;
      #1;
      check("rstw_async", {grant, wr_enable, rd_enable, a_ack, b_ack, wr_addr, rd_addr,
                           wr_data, a_rdata, b_rdata}, '0);
      @(negedge clk);
      ack_seen = 0;
      repeat (2) begin
         tick();
         if (a_ack || b_ack) ack_seen++;
      end
      check("rstw_no_ack", ack_seen, 0);
      rst = 0;
      tick();
      check("rstw_reissue", {grant, wr_enable, wr_addr, wr_data}, {2'b10, 1'b1, 24'h000777, 16'h7777});
      busy = 1;
      tick();
      busy = 0;
      tick();
      check("rstw_ack", {a_ack, b_ack, grant}, {1'b0, 1'b1, 2'b00});
      b_req = 0;
      tick();
      check("rstw_ack_pulse", {a_ack, b_ack}, 2'b00);

      // ---------------- simultaneous requests, round robin ----------------
      do_reset();
      a_we = 1; a_addr = 24'h00AAAA; a_wdata = 16'hAAAA;
      b_we = 1; b_addr = 24'h00BBBB; b_wdata = 16'hBBBB;
      a_req = 1; b_req = 1;
      for (int t = 0; t < 4; t++) begin
         exp_g    = (t % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr = (t % 2 == 0) ? 24'h00AAAA : 24'h00BBBB;
         waited = 0;
         while (!(wr_enable || rd_enable) && waited < 10) begin
            tick();
            waited++;
         end
         check($sformatf("rr%0d_grant", t), {(waited < 10), grant, wr_addr}, {1'b1, exp_g, exp_addr});
         busy = 1;
         tick();
         busy = 0;
         tick();
         check($sformatf("rr%0d_ack", t), {a_ack, b_ack, grant}, {exp_g[0], exp_g[1], 2'b00});
      end
      a_req = 0; b_req = 0;
      tick();
      tick();

      // ---------------- A read that captures data ----------------
      a_we = 0; a_addr = 24'h000042; a_req = 1;
      tick();
      check("rd_issue", {grant, rd_enable, wr_enable, rd_addr}, {2'b01, 1'b1, 1'b0, 24'h000042});
      busy = 1;
      tick();
      rd_ready = 1; rd_data = 16'h5A5A;
      tick();
      rd_ready = 0; rd_data = 16'h0; busy = 0;
      tick();
      check("rd_ack", {a_ack, a_rdata}, {1'b1, 16'h5A5A});
      a_req = 0;
      tick();

      // ---------------- controller ignores enable for 20 cycles ----------------
      a_we = 0; a_addr = 24'h00ABCD; a_req = 1;
      tick();
      hold_ok = 1;
      for (int c = 0; c < 20; c++) begin
         if (!(rd_enable && !wr_enable && rd_addr == 24'h00ABCD && wr_addr == 24'h00ABCD && grant == 2'b01))
            hold_ok = 0;
         tick();
      end
      check("refresh_hold", hold_ok, 1'b1);
      busy = 1;
      tick();
      busy = 0;
      acks = 0; others = 0; ens = 0;
      repeat (6) begin
         tick();
         if (a_ack) begin
            acks++;
            a_req = 0;
         end
         if (b_ack) others++;
         if (wr_enable || rd_enable) ens++;
      end
      check("refresh_acks", {acks[7:0], others[7:0], ens[7:0]}, {8'd1, 8'd0, 8'd0});
      check("noready_rdata", a_rdata, 16'h5A5A);

      // ---------------- a_req dropped in ARB_ISSUE ----------------
      a_we = 1; a_addr = 24'h00A0A0; a_wdata = 16'h1111; a_req = 1;
      tick();
      check("drop_issue", wr_enable, 1'b1);
      a_req = 0;
      tick();
      check("drop_hold", {grant, wr_enable, wr_addr, wr_data}, {2'b01, 1'b1, 24'h00A0A0, 16'h1111});
      busy = 1;
      tick();
      busy = 0;
      acks = 0; ens = 0;
      repeat (5) begin
         tick();
         if (a_ack) acks++;
         if (wr_enable || rd_enable) ens++;
      end
      check("drop_complete", {acks[7:0], ens[7:0], grant}, {8'd1, 8'd0, 2'b00});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sdram_host_arbiter.md
SDRAM_HOST_ARBITER -- requirements
Module: sdram_host_arbiter

Interface
REQ-001 SHALL have parameter HADDR_WIDTH, default 24: host address width, matching the SDRAM controller host port.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 a_req, b_req  in  1 each  port request, level; held until the port's ack.
REQ-006 a_we, b_we  in  1 each  1=write, 0=read; stable while req high.
REQ-007 a_addr, b_addr  in  HADDR_WIDTH each  request address; stable while req high.
REQ-008 a_wdata, b_wdata  in  16 each  write data; stable while req high.
REQ-009 a_ack, b_ack  out  1 each  one-cycle completion pulse.
REQ-010 a_rdata, b_rdata  out  16 each  read data, valid when the matching ack is high for a read.
REQ-011 grant  out  2  one-hot owner of the SDRAM controller: 01=A, 10=B, 00=none.
REQ-012 wr_enable, rd_enable  out  1 each  controller command strobes.
REQ-013 wr_addr, rd_addr  out  HADDR_WIDTH each  controller addresses.
REQ-014 wr_data  out  16  controller write data.
REQ-015 busy  in  1  controller busy.
REQ-016 rd_ready  in  1  controller read-data strobe.
REQ-017 rd_data  in  16  controller read data.

Function
REQ-018 The FSM SHALL have exactly three states: ARB_IDLE, ARB_ISSUE, ARB_WAIT.
REQ-019 All outputs SHALL be registered.
REQ-020 ARB_IDLE with any req high: select an owner, latch its we/addr/wdata, set grant, go to ARB_ISSUE.
- At most one of rd_enable/wr_enable is high in the following cycle, per the owner's we.
REQ-021 Selection SHALL be round-robin.
- Only one port requesting: that port wins.
- Both ports requesting: the port not granted last wins.
- last_grant updates on every selection.
REQ-022 ARB_ISSUE SHALL hold the enable, address and wr_data constant until busy is sampled high, then deassert both enables in the next cycle and go to ARB_WAIT.
- There is no timeout; the enable is held through controller init or refresh.
REQ-023 rd_addr and wr_addr SHALL both carry the owner's address whenever grant is non-zero.
REQ-024 In ARB_WAIT, when rd_ready is sampled high for a read, rd_data SHALL be captured into the owner's rdata register.
- The non-owner's rdata register is unchanged.
REQ-025 ARB_WAIT SHALL exit only when busy is sampled low.
- In the next cycle: the owner's ack pulses for exactly one cycle, grant=00, state=ARB_IDLE.
REQ-026 A read whose busy falls without rd_ready having been seen SHALL still ack, with rdata unchanged.
REQ-027 Latency:
- req high in ARB_IDLE -> enable high 1 cycle later.
- busy low sampled in ARB_WAIT -> ack 1 cycle later.
- Ack cycle -> earliest next enable 2 cycles later (ack cycle in ARB_IDLE, then ARB_ISSUE).
REQ-028 A req dropped before its ack SHALL NOT abort the transaction; the ack still pulses.
REQ-029 A request arriving during ack or while the other port is owned SHALL wait; no request is lost or duplicated.
REQ-030 The arbiter SHALL issue at most one controller transaction per grant.

Reset
REQ-031 On rst: state=ARB_IDLE, grant=00, enables=0, acks=0, rdata=0, addresses=0, wr_data=0, last_grant=B (so A wins the first tie).
REQ-032 rst asserted mid-transaction SHALL force the reset values immediately; the pending transaction is dropped with no ack.

Verification
REQ-033 Single A write: a_req, a_we=1, a_addr=0x012345, a_wdata=0xBEEF; controller busy high 2 cycles after wr_enable, low 5 cycles later.
- Required: wr_enable, wr_addr=0x012345, wr_data=0xBEEF until busy seen; a_ack one cycle after busy falls; b_ack never.
REQ-034 Single B read, addr 0x000010: rd_ready pulses with rd_data=0x1234.
- Required: b_ack with b_rdata=0x1234; a_rdata remains 0.
REQ-035 A and B request in the same cycle after reset.
- Required: A served first, then B; with both held high, grants alternate A,B,A,B over 4 transactions.
REQ-036 Controller ignores the enable (refresh) for 20 cycles before busy rises.
- Required: enable and address held all 20 cycles; exactly one ack.
REQ-037 rst asserted while in ARB_WAIT.
- Required: outputs at reset values the same cycle; no ack; next request is served normally.
REQ-038 a_req dropped in ARB_ISSUE.
- Required: transaction completes; a_ack pulses once; no re-issue.
